// File: rtl/lsu_controller.sv
// Load/store sequencer: req/gnt/rvalid data-memory handshake, pipeline stall, lane alignment and load extension.
// Build option: define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses instead of rejecting misaligned ones.
module lsu_controller #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3:0]            READ_WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [31:0]           WDATA,
    output logic                  STALL,
    output logic [31:0]           RDATA,
    output logic                  LOAD_VALID,
    output logic                  MISALIGN_ERR,
    output logic                  MEM_REQ,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [3:0]            MEM_BE,
    output logic [31:0]           MEM_WDATA,
    input  logic                  MEM_GNT,
    input  logic                  MEM_RVALID,
    input  logic [31:0]           MEM_RDATA
);

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE} state_t;

    state_t                state_q;
    logic [3:0]            cmd_q;
    logic [1:0]            off_q;
    logic                  busy_q;
    logic [31:0]           rdata_q;
    logic                  load_valid_q;
    logic                  misalign_err_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [3:0]            mem_be_q;
    logic [31:0]           mem_wdata_q;

    function automatic logic [3:0] size_mask(input logic [3:0] cmd);
        case (cmd)
            4'b1000, 4'b1011, 4'b1100: return 4'b0001;
            4'b1001, 4'b1101, 4'b1110: return 4'b0011;
            default:                   return 4'b1111;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] cmd);
        return (cmd == 4'b1011) || (cmd == 4'b1110) || (cmd == 4'b1111);
    endfunction

    // Little-endian merge of the (up to) two fetched words, shifted down so the access starts at byte 0.
    function automatic logic [31:0] merge_lanes(input logic [31:0] lo, input logic [23:0] hi,
                                                input logic [1:0] off);
        case (off)
            2'd0:    return lo;
            2'd1:    return {hi[7:0], lo[31:8]};
            2'd2:    return {hi[15:0], lo[31:16]};
            default: return {hi[23:0], lo[31:24]};
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [3:0] cmd, input logic [31:0] d);
        case (cmd)
            4'b1000: return {{24{d[7]}}, d[7:0]};
            4'b1001: return {{16{d[15]}}, d[15:0]};
            4'b1100: return {24'h0, d[7:0]};
            4'b1101: return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    logic [3:0]            in_mask;
    logic [3:0]            in_be1;
    logic [31:0]           in_wd1;
    logic [ADDR_WIDTH-1:0] in_base;
    logic                  in_misalign;

    assign in_mask = size_mask(READ_WRITE);
    assign in_be1  = in_mask << ADDR[1:0];
    assign in_wd1  = WDATA << {ADDR[1:0], 3'b000};
    assign in_base = {ADDR[ADDR_WIDTH-1:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic                  split_q;
    logic [ADDR_WIDTH-1:0] addr2_q;
    logic [3:0]            be2_q;
    logic [31:0]           wd2_q;
    logic [31:0]           rd1_q;
    logic [3:0]            in_be2;
    logic [31:0]           in_wd2;

    // Bytes that spill past lane 3 move to lanes 0 upward of the next word.
    always_comb begin
        in_be2 = '0;
        in_wd2 = '0;
        case (ADDR[1:0])
            2'd1:    begin in_be2 = in_mask >> 3; in_wd2 = {24'h0, WDATA[31:24]}; end
            2'd2:    begin in_be2 = in_mask >> 2; in_wd2 = {16'h0, WDATA[31:16]}; end
            2'd3:    begin in_be2 = in_mask >> 1; in_wd2 = {8'h0, WDATA[31:8]};   end
            default: ;
        endcase
    end

    assign in_misalign = 1'b0;
`else
    assign in_misalign = ((in_mask == 4'b0011) && ADDR[0]) ||
                         ((in_mask == 4'b1111) && (ADDR[1:0] != 2'b00));
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            cmd_q          <= '0;
            off_q          <= '0;
            busy_q         <= 1'b0;
            rdata_q        <= '0;
            load_valid_q   <= 1'b0;
            misalign_err_q <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_be_q       <= '0;
            mem_wdata_q    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q        <= 1'b0;
            addr2_q        <= '0;
            be2_q          <= '0;
            wd2_q          <= '0;
            rd1_q          <= '0;
`endif
        end else begin
            load_valid_q   <= 1'b0;
            misalign_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (READ_WRITE[3]) begin
                        cmd_q <= READ_WRITE;
                        off_q <= ADDR[1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
                        split_q <= |in_be2;
                        addr2_q <= in_base + ADDR_WIDTH'(4);
                        be2_q   <= in_be2;
                        wd2_q   <= in_wd2;
`endif
                        if (in_misalign) begin
                            state_q        <= DONE;
                            misalign_err_q <= 1'b1;
                        end else begin
                            state_q     <= REQ1;
                            busy_q      <= 1'b1;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store(READ_WRITE);
                            mem_addr_q  <= in_base;
                            mem_be_q    <= in_be1;
                            mem_wdata_q <= in_wd1;
                        end
                    end
                end
                REQ1: begin
                    if (MEM_GNT) begin
                        if (!is_store(cmd_q)) begin
                            state_q   <= WAIT1;
                            mem_req_q <= 1'b0;
                        end
`ifdef LSU_MISALIGN_SPLIT_EN
                        else if (split_q) begin
                            state_q     <= REQ2;
                            mem_addr_q  <= addr2_q;
                            mem_be_q    <= be2_q;
                            mem_wdata_q <= wd2_q;
                        end
`endif
                        else begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                        end
                    end
                end
                WAIT1: begin
                    if (MEM_RVALID) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        rd1_q <= MEM_RDATA;
                        if (split_q) begin
                            state_q     <= REQ2;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= addr2_q;
                            mem_be_q    <= be2_q;
                            mem_wdata_q <= wd2_q;
                        end else
`endif
                        begin
                            state_q      <= DONE;
                            busy_q       <= 1'b0;
                            rdata_q      <= extend(cmd_q, merge_lanes(MEM_RDATA, 24'h0, off_q));
                            load_valid_q <= 1'b1;
                        end
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                REQ2: begin
                    if (MEM_GNT) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (is_store(cmd_q)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= WAIT2;
                        end
                    end
                end
                WAIT2: begin
                    if (MEM_RVALID) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        rdata_q      <= extend(cmd_q, merge_lanes(rd1_q, MEM_RDATA[23:0], off_q));
                        load_valid_q <= 1'b1;
                    end
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The issue cycle stalls combinationally; the remaining busy cycles come from a register.
    assign STALL        = ((state_q == IDLE) && READ_WRITE[3]) || busy_q;
    assign RDATA        = rdata_q;
    assign LOAD_VALID   = load_valid_q;
    assign MISALIGN_ERR = misalign_err_q;
    assign MEM_REQ      = mem_req_q;
    assign MEM_WE       = mem_we_q;
    assign MEM_ADDR     = mem_addr_q;
    assign MEM_BE       = mem_be_q;
    assign MEM_WDATA    = mem_wdata_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed self-checking bench for lsu_controller with a req/gnt/rvalid memory responder and output monitor.
// Split-mode expectations are selected with LSU_MISALIGN_SPLIT_EN, matching the RTL build.
module tb_lsu_controller;

    localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, SB = 4'b1011;
    localparam logic [3:0] LBU = 4'b1100, LHU = 4'b1101, SH = 4'b1110, SW = 4'b1111;

    logic        CLK, RST;
    logic [3:0]  READ_WRITE;
    logic [31:0] ADDR, WDATA;
    logic        STALL, LOAD_VALID, MISALIGN_ERR;
    logic [31:0] RDATA;
    logic        MEM_REQ, MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_WDATA;
    logic        MEM_GNT, MEM_RVALID;
    logic [31:0] MEM_RDATA;

    lsu_controller #(.ADDR_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .READ_WRITE(READ_WRITE), .ADDR(ADDR), .WDATA(WDATA),
        .STALL(STALL), .RDATA(RDATA), .LOAD_VALID(LOAD_VALID), .MISALIGN_ERR(MISALIGN_ERR),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
        .MEM_WDATA(MEM_WDATA), .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Responder configuration and memory image
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    logic [31:0] mem [logic [31:0]];

    // Running totals kept by the monitor; tasks take deltas
    int          tot_stall = 0, tot_req = 0, tot_lv = 0, tot_me = 0, tot_unstable = 0, g_total = 0;
    logic [31:0] lv_data = '0;
    logic [31:0] g_addr [8];
    logic [3:0]  g_be   [8];
    logic        g_we   [8];
    logic [31:0] g_wd   [8];

    int d_stall, d_req, d_lv, d_me, d_unst, d_gr, g0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Memory responder plus output monitor, all on the falling edge
    initial begin
        int          gnt_cnt;
        int          rv_cnt;
        int          idx;
        logic [31:0] rv_word, s_addr, s_wd;
        logic [3:0]  s_be;
        logic        s_we;
        gnt_cnt = 0; rv_cnt = 0; rv_word = '0;
        s_addr = '0; s_wd = '0; s_be = '0; s_we = 1'b0;
        MEM_GNT = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = '0;
        forever begin
            @(negedge CLK);
            if (STALL) tot_stall++;
            if (LOAD_VALID) begin tot_lv++; lv_data = RDATA; end
            if (MISALIGN_ERR) tot_me++;
            MEM_GNT = 1'b0;
            MEM_RVALID = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin MEM_RVALID = 1'b1; MEM_RDATA = rv_word; end
            end
            if (MEM_REQ) begin
                tot_req++;
                if (gnt_cnt == 0) begin
                    s_addr = MEM_ADDR; s_be = MEM_BE; s_we = MEM_WE; s_wd = MEM_WDATA;
                end else if ({MEM_ADDR, MEM_BE, MEM_WE, MEM_WDATA} !== {s_addr, s_be, s_we, s_wd}) begin
                    tot_unstable++;
                end
                if (gnt_cnt == gnt_delay) begin
                    MEM_GNT = 1'b1;
                    idx = g_total % 8;
                    g_addr[idx] = MEM_ADDR; g_be[idx] = MEM_BE; g_we[idx] = MEM_WE; g_wd[idx] = MEM_WDATA;
                    g_total++;
                    gnt_cnt = 0;
                    if (!MEM_WE) begin rv_word = mem_rd(MEM_ADDR); rv_cnt = rv_delay + 1; end
                end else begin
                    gnt_cnt++;
                end
            end else begin
                gnt_cnt = 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic chk_grant(input string tag, input int i, input logic [31:0] addr,
                             input logic [3:0] be, input logic we);
        int k;
        k = (g0 + i) % 8;
        check_eq({tag, "_addr"}, g_addr[k], addr);
        check_eq({tag, "_be"}, {28'h0, g_be[k]}, {28'h0, be});
        check_eq({tag, "_we"}, {31'h0, g_we[k]}, {31'h0, we});
    endtask

    task automatic chk_reset_state(input string tag);
        check_eq({tag, "_stall"}, {31'h0, STALL}, 32'h0);
        check_eq({tag, "_req"}, {31'h0, MEM_REQ}, 32'h0);
        check_eq({tag, "_we"}, {31'h0, MEM_WE}, 32'h0);
        check_eq({tag, "_lv"}, {31'h0, LOAD_VALID}, 32'h0);
        check_eq({tag, "_me"}, {31'h0, MISALIGN_ERR}, 32'h0);
        check_eq({tag, "_rdata"}, RDATA, 32'h0);
        check_eq({tag, "_maddr"}, MEM_ADDR, 32'h0);
        check_eq({tag, "_mbe"}, {28'h0, MEM_BE}, 32'h0);
        check_eq({tag, "_mwdata"}, MEM_WDATA, 32'h0);
    endtask

    // Called at posedge+#1 with the DUT idle; returns at posedge+#1 with the DUT idle again.
    task automatic do_op(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] wd);
        int s0, r0, l0, m0, u0;
        bit done;
        s0 = tot_stall; r0 = tot_req; l0 = tot_lv; m0 = tot_me; u0 = tot_unstable; g0 = g_total;
        done = 1'b0;
        READ_WRITE = cmd; ADDR = a; WDATA = wd;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (!STALL) begin done = 1'b1; break; end
        end
        check_eq({tag, "_completes"}, {31'h0, done}, 32'h1);
        READ_WRITE = 4'b0000; ADDR = '0; WDATA = '0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        d_stall = tot_stall - s0; d_req = tot_req - r0; d_lv = tot_lv - l0;
        d_me = tot_me - m0; d_unst = tot_unstable - u0; d_gr = g_total - g0;
    endtask

    initial begin
        int l0;
        RST = 1'b1; READ_WRITE = 4'b0000; ADDR = '0; WDATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk_reset_state("por");
        RST = 1'b0;
        @(posedge CLK); #1;

        // Aligned word load, zero-wait memory
        mem[32'h100] = 32'hDEADBEEF;
        do_op("lw", LW, 32'h100, 32'h0);
        check_eq("lw_stall", d_stall, 3);
        check_eq("lw_grants", d_gr, 1);
        chk_grant("lw_g0", 0, 32'h100, 4'b1111, 1'b0);
        check_eq("lw_lv", d_lv, 1);
        check_eq("lw_lvdata", lv_data, 32'hDEADBEEF);
        check_eq("lw_rdata", RDATA, 32'hDEADBEEF);

        // Byte loads from the top lane, signed and unsigned
        mem[32'h100] = 32'h80FFFFFF;
        do_op("lb", LB, 32'h103, 32'h0);
        chk_grant("lb_g0", 0, 32'h100, 4'b1000, 1'b0);
        check_eq("lb_rdata", RDATA, 32'hFFFFFF80);
        do_op("lbu", LBU, 32'h103, 32'h0);
        check_eq("lbu_rdata", RDATA, 32'h00000080);

        // Halfword loads at offset 2, one RVALID wait cycle
        mem[32'h100] = 32'h9ABC1234;
        rv_delay = 1;
        do_op("lh", LH, 32'h102, 32'h0);
        check_eq("lh_stall", d_stall, 4);
        chk_grant("lh_g0", 0, 32'h100, 4'b1100, 1'b0);
        check_eq("lh_rdata", RDATA, 32'hFFFF9ABC);
        rv_delay = 0;
        do_op("lhu", LHU, 32'h102, 32'h0);
        check_eq("lhu_rdata", RDATA, 32'h00009ABC);

        // Halfword store with grant delayed 3 cycles
        gnt_delay = 3;
        do_op("sh", SH, 32'h202, 32'h1234ABCD);
        check_eq("sh_req_cycles", d_req, 4);
        check_eq("sh_stable", d_unst, 0);
        check_eq("sh_stall", d_stall, 5);
        chk_grant("sh_g0", 0, 32'h200, 4'b1100, 1'b1);
        check_eq("sh_wdata", g_wd[g0 % 8], 32'hABCD0000);
        check_eq("sh_lv", d_lv, 0);
        check_eq("sh_rdata_hold", RDATA, 32'h00009ABC);
        gnt_delay = 0;

        // Byte store, zero-wait
        do_op("sb", SB, 32'h101, 32'h000000A5);
        check_eq("sb_stall", d_stall, 2);
        chk_grant("sb_g0", 0, 32'h100, 4'b0010, 1'b1);
        check_eq("sb_wdata", g_wd[g0 % 8], 32'h0000A500);

`ifdef LSU_MISALIGN_SPLIT_EN
        mem[32'h100] = 32'h11223344;
        mem[32'h104] = 32'h55667788;
        do_op("lwx", LW, 32'h103, 32'h0);
        check_eq("lwx_grants", d_gr, 2);
        chk_grant("lwx_g0", 0, 32'h100, 4'b1000, 1'b0);
        chk_grant("lwx_g1", 1, 32'h104, 4'b0111, 1'b0);
        check_eq("lwx_stall", d_stall, 5);
        check_eq("lwx_me", d_me, 0);
        check_eq("lwx_rdata", RDATA, 32'h66778811);

        do_op("swx", SW, 32'h0FE, 32'hCAFEBABE);
        check_eq("swx_grants", d_gr, 2);
        chk_grant("swx_g0", 0, 32'h0FC, 4'b1100, 1'b1);
        check_eq("swx_wd0", g_wd[g0 % 8], 32'hBABE0000);
        chk_grant("swx_g1", 1, 32'h100, 4'b0011, 1'b1);
        check_eq("swx_wd1", g_wd[(g0 + 1) % 8], 32'h0000CAFE);
        check_eq("swx_stall", d_stall, 3);

        do_op("lhm", LH, 32'h101, 32'h0);
        check_eq("lhm_grants", d_gr, 1);
        chk_grant("lhm_g0", 0, 32'h100, 4'b0110, 1'b0);
        check_eq("lhm_me", d_me, 0);
        check_eq("lhm_rdata", RDATA, 32'h00002233);
`else
        do_op("lwx", LW, 32'h103, 32'h0);
        check_eq("lwx_me", d_me, 1);
        check_eq("lwx_req", d_req, 0);
        check_eq("lwx_lv", d_lv, 0);
        check_eq("lwx_stall", d_stall, 1);
        check_eq("lwx_rdata_hold", RDATA, 32'h00009ABC);

        do_op("swx", SW, 32'h0FE, 32'hCAFEBABE);
        check_eq("swx_me", d_me, 1);
        check_eq("swx_req", d_req, 0);

        do_op("lhm", LH, 32'h101, 32'h0);
        check_eq("lhm_me", d_me, 1);
        check_eq("lhm_req", d_req, 0);
        check_eq("lhm_rdata_hold", RDATA, 32'h00009ABC);
`endif

        // Reset while waiting for read data; the late RVALID must be ignored
        rv_delay = 3;
        mem[32'h300] = 32'h12345678;
        l0 = tot_lv;
        READ_WRITE = LW; ADDR = 32'h300; WDATA = '0;
        @(posedge CLK); #1;
        check_eq("rst_in_req1", {31'h0, MEM_REQ}, 32'h1);
        @(posedge CLK); #1;
        RST = 1'b1; READ_WRITE = 4'b0000; ADDR = '0;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk_reset_state("midrst");
        repeat (8) @(posedge CLK);
        #1;
        check_eq("midrst_no_lv", tot_lv - l0, 0);
        check_eq("midrst_rdata", RDATA, 32'h0);
        check_eq("midrst_stall", {31'h0, STALL}, 32'h0);

        rv_delay = 0;
        mem[32'h100] = 32'hA5A50F0F;
        do_op("lw2", LW, 32'h100, 32'h0);
        check_eq("lw2_stall", d_stall, 3);
        check_eq("lw2_lv", d_lv, 1);
        check_eq("lw2_rdata", RDATA, 32'hA5A50F0F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_controller.md
# lsu_controller

Multi-cycle load/store sequencer between the core's decode/execute stage and the data-memory port. It takes the 4-bit memory command produced by the control unit plus the effective address and store data. It runs a request/grant/response handshake with data memory, stalls the pipeline until the access completes, and returns aligned, sign- or zero-extended load data. Accesses that cross a word boundary are optionally split into two word transactions.

## Interface
- ADDR_WIDTH, 32, width of ADDR and MEM_ADDR
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- READ_WRITE  in  4  command from control unit; bit3=1 means access. 1000 LB, 1001 LH, 1010 LW, 1011 SB, 1100 LBU, 1101 LHU, 1110 SH, 1111 SW
- ADDR  in  ADDR_WIDTH  effective byte address
- WDATA  in  32  store data (rs2)
- STALL  out  1  pipeline hold request
- RDATA  out  32  extended load result
- LOAD_VALID  out  1  one-cycle pulse: RDATA updated this cycle
- MISALIGN_ERR  out  1  one-cycle pulse: access rejected
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  1 = write
- MEM_ADDR  out  ADDR_WIDTH  word address (bits [1:0] = 0)
- MEM_BE  out  4  byte enables, little-endian
- MEM_WDATA  out  32  lane-aligned write data
- MEM_GNT  in  1  request accepted this cycle
- MEM_RVALID  in  1  read data valid
- MEM_RDATA  in  32  read data

## Operation
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE.
- IDLE: READ_WRITE[3]=1 → latch command, ADDR, WDATA; STALL=1 combinationally this cycle; next state REQ1. READ_WRITE[3]=0 → stay idle, STALL=0.
- Inputs READ_WRITE, ADDR and WDATA are ignored outside IDLE. The pipeline holds them stable while STALL=1.
- REQ1/REQ2: MEM_REQ=1 with MEM_ADDR, MEM_BE, MEM_WE, MEM_WDATA held constant until MEM_GNT=1.
  - On grant for a load → WAIT1/WAIT2.
  - On grant for a store → REQ2 if a second part is pending, else DONE.
- WAIT1/WAIT2: wait for MEM_RVALID and capture MEM_RDATA. Then go to REQ2 if split, else DONE. MEM_RVALID is ignored in all other states.
- DONE: STALL=0 for one cycle. For loads, RDATA is written and LOAD_VALID=1. Next state IDLE. The same command still on READ_WRITE is not re-issued.
- Size and offset: offset = ADDR[1:0]; size 1/2/4 bytes.
  - MEM_BE = size mask << offset, truncated to the first word.
  - MEM_WDATA = WDATA << 8·offset.
- Split access: offset+size > 4.
  - First access at ADDR & ~3 with the lower lanes.
  - Second access at (ADDR & ~3)+4 with the remaining bytes in lanes 0 upward.
  - Load bytes are merged little-endian before extension.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- RDATA holds its last value until the next completed load.
- MISALIGN_ERR is never asserted when the split feature is compiled in.
- Address arithmetic for the second word wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset: state=IDLE. STALL, MEM_REQ, MEM_WE, LOAD_VALID, MISALIGN_ERR = 0. RDATA, MEM_ADDR, MEM_BE, MEM_WDATA = 0.
- Reset mid-operation abandons the access. MEM_REQ drops in the cycle after RST is sampled, and a late MEM_RVALID is ignored.
- Aligned load, zero-wait memory (GNT in REQ1, RVALID next cycle): 4 cycles (IDLE, REQ1, WAIT1, DONE). STALL high 3 cycles.
- Aligned store, zero-wait: 3 cycles (IDLE, REQ1, DONE). STALL high 2 cycles.
- Each GNT or RVALID wait cycle adds exactly one STALL cycle.
- Split access adds REQ2 (+WAIT2 for loads).
- MEM_GNT seen outside REQ1/REQ2 is ignored.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: misaligned accesses that stay inside one word use a single transaction; word-crossing accesses use the two-transaction split above.
- LSU_MISALIGN_SPLIT_EN undefined:
  - Any LH/LHU/SH with ADDR[0]=1, or LW/SW with ADDR[1:0]≠0, goes IDLE→DONE with no MEM_REQ.
  - In DONE: MISALIGN_ERR=1, LOAD_VALID=0, and RDATA is unchanged.
  - REQ2/WAIT2 logic is not built.

## Test plan
- LW ADDR=0x100, GNT immediate, RVALID next cycle with 0xDEADBEEF → MEM_ADDR=0x100, MEM_BE=1111, STALL 3 cycles, then LOAD_VALID=1 with RDATA=0xDEADBEEF.
- LB ADDR=0x103, memory word 0x80FFFFFF → MEM_BE=1000, RDATA=0xFFFFFF80. LBU at the same address → RDATA=0x00000080.
- SH ADDR=0x202, WDATA=0x1234ABCD, GNT delayed 3 cycles → MEM_REQ high 4 cycles with MEM_ADDR=0x200, MEM_BE=1100, MEM_WE=1, MEM_WDATA=0xABCD0000 stable. STALL=0 in DONE.
- With split enabled, LW ADDR=0x103, mem[0x100]=0x11223344, mem[0x104]=0x55667788 → accesses 0x100/BE=1000 then 0x104/BE=0111, RDATA=0x66778811. Without split → MISALIGN_ERR pulse, no MEM_REQ.
- With split enabled, SW ADDR=0x0FE, WDATA=0xCAFEBABE → 0x0FC/BE=1100/WDATA=0xBABE0000, then 0x100/BE=0011/WDATA=0x0000CAFE.
- RST asserted in WAIT1, then MEM_RVALID=1 with 0x12345678 → all outputs 0, RDATA unchanged at 0, LOAD_VALID never pulses. The next LW completes normally.
